// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Imported by the fetch top level and its buffer.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DROP  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, instr} entries between memory and decode.
// Flush wins over push and pop; push into a full buffer needs a same-cycle pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is 2^n.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents are never observed while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// RV32I fetch front end: owns the PC, issues one word read at a time,
// buffers returned words and handles redirects from execute.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t     state;
    logic [31:0]      pc;
    logic             req_q;
    logic [31:0]      addr_q;
    logic [31:0]      target;
    logic             accepted;
    logic             push;
    logic             pop;
    logic             room_after;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after;
    logic             empty;
    logic             full;
    fetch_entry_t     head;
    fetch_entry_t     wr_entry;

    assign target      = redirect_pc & ~32'd3;
    assign accepted    = req_q && imem_ack;
    assign push        = accepted && (state == ST_FETCH) && !redirect_valid;
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign count_after = count + CNT_W'(push) - CNT_W'(pop);
    assign room_after  = (count_after < CNT_W'(BUF_DEPTH));
    assign wr_entry    = '{pc: pc, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (wr_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    // Fetch control: PC, request and held address, drop-after-redirect state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_FETCH;
            pc     <= RESET_PC;
            req_q  <= 1'b0;
            addr_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= target;
            if (req_q && !imem_ack) begin
                // Old access stays on the bus until acked, then is thrown away.
                state <= ST_DROP;
            end else begin
                state  <= ST_FETCH;
                req_q  <= 1'b1;
                addr_q <= target;
            end
        end else begin
            unique case (state)
                ST_FETCH: begin
                    if (accepted) begin
                        pc     <= pc + 32'd4;
                        addr_q <= pc + 32'd4;
                        req_q  <= room_after;
                    end else if (!req_q) begin
                        req_q  <= !full || pop;
                        addr_q <= pc;
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        state  <= ST_FETCH;
                        req_q  <= 1'b0;
                        addr_q <= pc;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = !empty;
    assign instr       = empty ? NOP_INSTR : head.instr;
    assign instr_pc    = empty ? 32'd0 : head.pc;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch front end that produces the 32-bit RV32I instruction stream consumed by the decoder. It owns the PC and issues word reads to instruction memory over a req/ack handshake. Returned words are buffered in a small FIFO and presented to the decoder with a valid/ready handshake. It also accepts redirects (taken branch or jump) from the execute stage and flushes stale instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
BUF_DEPTH, 2, FIFO entries of {pc, instr}; a power of two, at least 2.

Ports:
clk  in  1  Rising-edge clock.
rst  in  1  Asynchronous, active-high reset.
imem_req  out  1  Read request. Held high until acked.
imem_addr  out  32  Word address of the request; bits [1:0] are always 00.
imem_ack  in  1  Read data valid. May be asserted in the same cycle as imem_req (zero-wait) or any later cycle.
imem_rdata  in  32  Instruction word. Sampled only when imem_req and imem_ack are both high.
redirect_valid  in  1  One-cycle pulse that redirects the PC.
redirect_pc  in  32  New PC. Bits [1:0] are forced to 00.
instr_valid  out  1  Instruction present at the FIFO head.
instr  out  32  Head instruction; 32'h0000_0013 (ADDI x0,x0,0) when instr_valid is 0.
instr_pc  out  32  PC of the head instruction; 0 when instr_valid is 0.
instr_ready  in  1  Decoder accepts the head instruction this cycle.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, FIFO empty, state=FETCH, imem_req=0, instr_valid=0, instr=NOP, instr_pc=0.
- imem_req is registered. It first rises on the first clock edge after reset deasserts.
- At most one outstanding request. imem_addr=pc, and both imem_req and imem_addr stay stable from assertion until ack.
- Pop: instr_valid && instr_ready. Push: accepted ack in state FETCH.
- On an accepted ack in FETCH: push {pc, imem_rdata} and set pc<=pc+4 (wraps modulo 2^32). imem_req stays high the next cycle if count_after (count after this cycle's push/pop) < BUF_DEPTH; otherwise it drops. This gives sustained 1 instr/cycle with zero-wait memory and instr_ready=1.
- While imem_req=0 in FETCH: assert it on the next edge once count_after < BUF_DEPTH.
- Full FIFO: no new request is issued. Because only one request is ever outstanding, a push can never overflow the FIFO.
- Simultaneous push and pop: count unchanged, and a full FIFO stays full without loss.
- States:
  - FETCH: normal operation.
  - DROP: a request was outstanding at redirect. Keep imem_req and imem_addr at the old values until ack, discard that data, then return to FETCH with imem_req deasserted for one cycle. The next request uses the redirect PC.
- Redirect (redirect_valid=1), in any state:
  - Flush the FIFO; instr_valid=0 the next cycle.
  - pc<=redirect_pc&~3.
  - If a request is outstanding and unacked this cycle, go to DROP. Otherwise stay in FETCH and issue at the new PC on the next edge.
  - Redirect in the same cycle as an ack: the ack completes the old request and its data is discarded (not pushed), with no DROP.
  - Redirect while already in DROP: update pc and stay in DROP.
  - Redirect takes priority over push and pop in the same cycle.
- instr and instr_pc come combinationally from the FIFO head, gated to NOP/0 when the FIFO is empty.
- Async reset mid-request: imem_req drops immediately. The memory must abandon the access.

Decomposition:
- Shared package fetch_pkg holds: NOP_INSTR=32'h0000_0013, the default RESET_PC, and the state encoding (FETCH, DROP).
- Sub-module fetch_fifo: BUF_DEPTH x 64-bit synchronous FIFO with push, pop, flush, count, empty and full.

Test Plan:
- Reset release, zero-wait memory, instr_ready=1 -> imem_addr 0x0, 0x4, 0x8… on consecutive cycles; instr_pc 0x0, 0x4… one per cycle with no bubbles after the first.
- instr_ready=0 from reset -> two pushes (0x0, 0x4), then imem_req low with imem_addr=0x8. Raise instr_ready -> pops 0x0 and 0x4, requests resume at 0x8, no duplicates or gaps.
- FIFO full, redirect_pc=0x100 -> instr_valid=0 the next cycle; next request at 0x100; first delivered instr_pc=0x100.
- 3-cycle-latency memory, redirect_pc=0x203 one cycle after req at 0x10 -> req/addr held at 0x10 until ack; that data is never presented; next req at 0x200; delivered instr_pc 0x200, 0x204.
- Redirect coincident with ack of 0x8 -> 0x8 never appears; next req at the redirect target; no DROP cycle.
- rst asserted mid-request (asynchronously, between clock edges) -> imem_req and instr_valid go low immediately; after release, first req at RESET_PC.
